opctrl_issue_seq: RTL

- Single-issue sequencer for micro-instructions (uinstr_t: vrs1, vrs2, vrs3, opcode).
- Accepts one instruction at a time and reads source operands vrs1/vrs2 from the vector register file.
- Dispatches opcode and operands to the execution unit over a valid/ready handshake, then writes the low half of the wide result back to vrs3.
- Sits between the instruction source and the RF/execution datapath; keeps a retired-instruction counter.

---
 rtl/config_pkg.sv | 18 +
 rtl/opctrl_issue_seq.sv | 96 +++++++++
 2 files changed

// File: rtl/config_pkg.sv
// config_pkg: shared widths, datapath types and the issue-sequencer state encoding.
package config_pkg;
  localparam int AW = 4;
  localparam int DW = 20;
  localparam int CW = 4;
  localparam int RCW_DEFAULT = 16;
  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;
  typedef logic [2*DW-1:0] w_data_t;
  typedef logic [CW-1:0] code_t;
  typedef struct packed {
    addr_t vrs1;
    addr_t vrs2;
    addr_t vrs3;
    code_t opcode;
  } uinstr_t;
  typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT, WB, WB_HI} opctrl_state_t;
endpackage

// File: rtl/opctrl_issue_seq.sv
// opctrl_issue_seq: single-issue read/dispatch/write-back sequencer with retired counter.
// OPCTRL_WIDE_WB_EN adds a second write-back cycle for the upper result half to vrs3+1.
module opctrl_issue_seq
  import config_pkg::*;
#(
  parameter int RCW = RCW_DEFAULT
) (
  input  logic           clk_i,
  input  logic           arst_ni,
  input  uinstr_t        uinstr_i,
  input  logic           uinstr_valid_i,
  output logic           uinstr_ready_o,
  output addr_t          rf_raddr1_o,
  output addr_t          rf_raddr2_o,
  input  data_t          rf_rdata1_i,
  input  data_t          rf_rdata2_i,
  output logic           ex_valid_o,
  input  logic           ex_ready_i,
  output code_t          ex_opcode_o,
  output data_t          ex_op1_o,
  output data_t          ex_op2_o,
  input  logic           ex_result_valid_i,
  input  w_data_t        ex_result_i,
  output logic           rf_we_o,
  output addr_t          rf_waddr_o,
  output data_t          rf_wdata_o,
  output logic           busy_o,
  output logic [RCW-1:0] retired_o
);
  opctrl_state_t  state;
  uinstr_t        instr;
  data_t          op1, op2;
  w_data_t        res;
  logic [RCW-1:0] retired;
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state   <= IDLE;
      instr   <= '0;
      op1     <= '0;
      op2     <= '0;
      res     <= '0;
      retired <= '0;
    end else begin
      case (state)
        IDLE: if (uinstr_valid_i) begin
          instr <= uinstr_i;
          state <= READ;
        end
        READ: begin
          op1   <= rf_rdata1_i;
          op2   <= rf_rdata2_i;
          state <= ISSUE;
        end
        ISSUE: if (ex_ready_i) state <= WAIT;
        WAIT: if (ex_result_valid_i) begin
          res   <= ex_result_i;
          state <= WB;
        end
`ifdef OPCTRL_WIDE_WB_EN
        WB: state <= WB_HI;
        WB_HI: begin
          retired <= retired + 1'b1;
          state   <= IDLE;
        end
`else
        WB: begin
          retired <= retired + 1'b1;
          state   <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
  // ready is gated by reset so it reads 0 while held and 1 the moment it lifts
  assign uinstr_ready_o = arst_ni && (state == IDLE);
  assign rf_raddr1_o    = instr.vrs1;
  assign rf_raddr2_o    = instr.vrs2;
  assign ex_valid_o     = (state == ISSUE);
  assign ex_opcode_o    = instr.opcode;
  assign ex_op1_o       = op1;
  assign ex_op2_o       = op2;
  assign busy_o         = (state != IDLE);
  assign retired_o      = retired;
`ifdef OPCTRL_WIDE_WB_EN
  assign rf_we_o    = (state == WB) || (state == WB_HI);
  assign rf_waddr_o = (state == WB_HI) ? instr.vrs3 + 1'b1 : instr.vrs3;
  assign rf_wdata_o = (state == WB_HI) ? res[2*DW-1:DW] : res[DW-1:0];
`else
  logic unused_res_hi;
  assign unused_res_hi = ^res[2*DW-1:DW];
  assign rf_we_o    = (state == WB);
  assign rf_waddr_o = instr.vrs3;
  assign rf_wdata_o = res[DW-1:0];
`endif
endmodule
